// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: shared types and constants for the I2S receiver.
//   rx_state_e   : receiver framing state (sync / left word / right word)
//   CH_LEFT/RIGHT: WS level that selects each channel
//   SYNC_STAGES  : flop count in each pin synchroniser
package i2s_rx_pkg;

    typedef enum logic [1:0] {
        StSync  = 2'd0,
        StLeft  = 2'd1,
        StRight = 2'd2
    } rx_state_e;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo: first-word-fall-through FIFO holding stereo pairs. The head entry is read straight
// from the storage registers, so a push into an empty FIFO is visible on the next cycle.
// A push while full is legal only together with a pop (the head slot is reused).
//   por_clk    in   system clock
//   rst_n      in   asynchronous active-low reset
//   push       in   write push_data
//   push_data  in   WIDTH-bit pair
//   pop        in   drop the head entry
//   full       out  DEPTH entries held
//   head_data  out  oldest entry (zero when empty after reset)
//   head_valid out  at least one entry held
// DEPTH must be a power of two, at least 2.
module i2s_rx_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             por_clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;

    assign do_pop     = pop & head_valid;
    assign full       = (count_q == CNT_W'(DEPTH));
    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[rd_ptr_q];

    always_ff @(posedge por_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: Philips-format I2S receiver. BCLK/WS/DATA are synchronised into por_clk, the stream is
// deserialised MSB-first and each {left, right} pair is offered on a valid/ready interface.
//   por_clk       in   system clock
//   rst_n         in   asynchronous active-low reset
//   i2s_rx_clk    in   bit clock from codec (asynchronous)
//   i2s_rx_ws     in   word select, 0 = left, 1 = right
//   i2s_rx_data   in   serial data, MSB first
//   sample_left   out  left word of head pair
//   sample_right  out  right word of head pair
//   sample_valid  out  head pair available
//   sample_ready  in   consumer accepts head pair
//   overrun       out  sticky: a complete pair was dropped
//   overrun_clr   in   synchronous clear of overrun (a same-cycle drop wins)
// Build option: define I2S_RX_FIFO_EN for a FIFO_DEPTH-pair FIFO; otherwise one holding register.
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  por_clk,
    input  logic                  rst_n,
    input  logic                  i2s_rx_clk,
    input  logic                  i2s_rx_ws,
    input  logic                  i2s_rx_data,
    output logic [DATA_WIDTH-1:0] sample_left,
    output logic [DATA_WIDTH-1:0] sample_right,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    localparam logic [DATA_WIDTH-1:0] MASK_INIT = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    // Pin synchronisers; BCLK gets one extra stage for edge detection.
    logic [SYNC_STAGES:0]   bclk_sync_q;
    logic [SYNC_STAGES-1:0] ws_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   rise;
    logic                   ws_now;
    logic                   data_now;

    rx_state_e             state_q, state_d;
    logic                  ws_prev_q, ws_prev_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    // One-hot pointer to the next bit position; reaches zero once DATA_WIDTH bits are taken,
    // which discards any further bits of a longer slot.
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic                  have_left_q, have_left_d;
    logic                  overrun_q, overrun_d;

    logic [DATA_WIDTH-1:0]   word;
    logic                    word_end;
    logic                    commit;
    logic [2*DATA_WIDTH-1:0] pair;
    logic                    accept;
    logic                    pop;
    logic                    drop;

    assign rise     = bclk_sync_q[SYNC_STAGES-1] & ~bclk_sync_q[SYNC_STAGES];
    assign ws_now   = ws_sync_q[SYNC_STAGES-1];
    assign data_now = data_sync_q[SYNC_STAGES-1];

    // Word including the bit captured on this edge; that bit belongs to channel ws_prev_q.
    assign word     = shift_q | (mask_q & {DATA_WIDTH{data_now}});
    assign word_end = (ws_now != ws_prev_q);
    assign pair     = {left_q, word};

    always_comb begin
        state_d     = state_q;
        ws_prev_d   = ws_prev_q;
        shift_d     = shift_q;
        mask_d      = mask_q;
        left_d      = left_q;
        have_left_d = have_left_q;
        commit      = 1'b0;
        if (rise) begin
            ws_prev_d = ws_now;
            unique case (state_q)
                StSync: begin
                    // Only a change to left starts framing, so a right word is never first.
                    if (word_end && ws_now == CH_LEFT) begin
                        state_d = StLeft;
                        shift_d = '0;
                        mask_d  = MASK_INIT;
                    end
                end
                StLeft: begin
                    if (word_end) begin
                        left_d      = word;
                        have_left_d = 1'b1;
                        state_d     = StRight;
                        shift_d     = '0;
                        mask_d      = MASK_INIT;
                    end else begin
                        shift_d = word;
                        mask_d  = mask_q >> 1;
                    end
                end
                StRight: begin
                    if (word_end) begin
                        commit      = have_left_q;
                        have_left_d = 1'b0;
                        state_d     = StLeft;
                        shift_d     = '0;
                        mask_d      = MASK_INIT;
                    end else begin
                        shift_d = word;
                        mask_d  = mask_q >> 1;
                    end
                end
                default: state_d = StSync;
            endcase
        end
    end

    assign pop       = sample_valid & sample_ready;
    assign drop      = commit & ~accept;
    assign overrun_d = drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
    assign overrun   = overrun_q;

    always_ff @(posedge por_clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync_q <= '0;
            ws_sync_q   <= '0;
            data_sync_q <= '0;
            state_q     <= StSync;
            ws_prev_q   <= CH_LEFT;
            shift_q     <= '0;
            mask_q      <= MASK_INIT;
            left_q      <= '0;
            have_left_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-1:0], i2s_rx_clk};
            ws_sync_q   <= {ws_sync_q[SYNC_STAGES-2:0], i2s_rx_ws};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], i2s_rx_data};
            state_q     <= state_d;
            ws_prev_q   <= ws_prev_d;
            shift_q     <= shift_d;
            mask_q      <= mask_d;
            left_q      <= left_d;
            have_left_q <= have_left_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef I2S_RX_FIFO_EN
    logic                    fifo_full;
    logic [2*DATA_WIDTH-1:0] head;

    // A full FIFO still takes the pair when the head leaves in the same cycle.
    assign accept = ~fifo_full | pop;

    i2s_rx_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .por_clk    (por_clk),
        .rst_n      (rst_n),
        .push       (commit & accept),
        .push_data  (pair),
        .pop        (pop),
        .full       (fifo_full),
        .head_data  (head),
        .head_valid (sample_valid)
    );

    assign sample_left  = head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign sample_right = head[DATA_WIDTH-1:0];
`else
    logic [2*DATA_WIDTH-1:0] hold_q;
    logic                    hold_valid_q;
    // Depth only matters when the FIFO is built.
    logic                    unused_fifo_depth;

    assign unused_fifo_depth = ^FIFO_DEPTH;
    assign accept            = ~hold_valid_q | pop;

    always_ff @(posedge por_clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else if (commit && accept) begin
            hold_q       <= pair;
            hold_valid_q <= 1'b1;
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end

    assign sample_valid = hold_valid_q;
    assign sample_left  = hold_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign sample_right = hold_q[DATA_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed bench for i2s_rx. All pins change on por_clk falling edges; a monitor
// samples 1 ns after each falling edge and records every accepted pair.
module tb_i2s_rx;

    localparam int unsigned DW = 16;
    localparam int unsigned FD = 4;
`ifdef I2S_RX_FIFO_EN
    localparam int BUF = FD;
`else
    localparam int BUF = 1;
`endif

    logic por_clk = 1'b0;
    logic rst_n = 1'b0;
    logic i2s_clk = 1'b0;
    logic i2s_ws = 1'b0;
    logic i2s_data = 1'b0;
    logic sample_ready = 1'b0;
    logic overrun_clr = 1'b0;
    logic [DW-1:0] sample_left;
    logic [DW-1:0] sample_right;
    logic sample_valid;
    logic overrun;

    int compared = 0;
    int failed = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int vrise_cyc = -1;
    int valid_cycles = 0;
    logic valid_prev = 1'b0;
    logic [2*DW-1:0] got[$];
    logic [31:0] sh;

    always #5 por_clk = ~por_clk;

    i2s_rx #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .por_clk      (por_clk),
        .rst_n        (rst_n),
        .i2s_rx_clk   (i2s_clk),
        .i2s_rx_ws    (i2s_ws),
        .i2s_rx_data  (i2s_data),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    always begin
        @(negedge por_clk);
        #1;
        cyc++;
        if (sample_valid && !valid_prev) vrise_cyc = cyc;
        if (sample_valid) valid_cycles++;
        if (sample_valid && sample_ready) got.push_back({sample_left, sample_right});
        valid_prev = sample_valid;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One BCLK period: low 4 clk, high 4 clk. clr pulses overrun_clr in the commit cycle.
    task automatic bclk_cycle(input logic ws, input logic d, input logic clr);
        i2s_ws   = ws;
        i2s_data = d;
        i2s_clk  = 1'b0;
        repeat (4) @(negedge por_clk);
        i2s_clk  = 1'b1;
        rise_cyc = cyc;
        repeat (2) @(negedge por_clk);
        if (clr) overrun_clr = 1'b1;
        @(negedge por_clk);
        overrun_clr = 1'b0;
        @(negedge por_clk);
    endtask

    // Full frame of s-bit slots; l and r are right-justified slot contents.
    task automatic frame(input logic [31:0] l, input logic [31:0] r, input int s,
                         input logic clr);
        logic [31:0] fs;
        fs = l << (32 - s);
        for (int j = s - 1; j >= 0; j--) begin
            bclk_cycle(j == 0, fs[31], 1'b0);
            fs = fs << 1;
        end
        fs = r << (32 - s);
        for (int j = s - 1; j >= 0; j--) begin
            bclk_cycle(j != 0, fs[31], clr && (j == 0));
            fs = fs << 1;
        end
    endtask

    initial begin
        @(negedge por_clk);
        repeat (3) @(negedge por_clk);
        check("rst_left_in", 64'(sample_left), 64'd0);
        check("rst_valid_in", 64'(sample_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge por_clk);
        check("rst_left", 64'(sample_left), 64'd0);
        check("rst_right", 64'(sample_right), 64'd0);
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);

        // 32-bit slots, extra LSBs ignored
        sample_ready = 1'b1;
        bclk_cycle(1'b1, 1'b0, 1'b0);
        bclk_cycle(1'b0, 1'b0, 1'b0);
        got.delete();
        valid_cycles = 0;
        vrise_cyc = -1;
        frame(32'hA5C3_5A5A, 32'h1234_FFFF, 32, 1'b0);
        check("t1_count", 64'(got.size()), 64'd1);
        check("t1_pair", 64'(got[0]), 64'hA5C3_1234);
        check("t1_valid_cycles", 64'(valid_cycles), 64'd1);
        check("t1_latency", 64'(vrise_cyc - rise_cyc), 64'd4);
        check("t1_overrun", 64'(overrun), 64'd0);

        // 12-bit slots, MSB-aligned with zero fill
        got.delete();
        frame(32'hFFF, 32'h801, 12, 1'b0);
        check("t2_count", 64'(got.size()), 64'd1);
        check("t2_pair", 64'(got[0]), 64'hFFF0_8010);

        // Reset held across a left word, released mid right word
        got.delete();
        rst_n = 1'b0;
        sh = 32'hDEAD_0000;
        for (int j = 15; j >= 0; j--) begin
            bclk_cycle(j == 0, sh[31], 1'b0);
            sh = sh << 1;
        end
        sh = 32'hBEEF_0000;
        for (int j = 15; j >= 8; j--) begin
            bclk_cycle(1'b1, sh[31], 1'b0);
            sh = sh << 1;
        end
        rst_n = 1'b1;
        for (int j = 7; j >= 0; j--) begin
            bclk_cycle(j != 0, sh[31], 1'b0);
            sh = sh << 1;
        end
        frame(32'h1111, 32'h2222, 16, 1'b0);
        frame(32'h3333, 32'h4444, 16, 1'b0);
        frame(32'h5555, 32'h6666, 16, 1'b0);
        check("t3_count", 64'(got.size()), 64'd3);
        check("t3_pair0", 64'(got[0]), 64'h1111_2222);
        check("t3_pair1", 64'(got[1]), 64'h3333_4444);
        check("t3_pair2", 64'(got[2]), 64'h5555_6666);

        // Consumer stalled for 6 frames
        got.delete();
        sample_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            frame(32'(32'h1000 + k), 32'(32'h2000 + k), 16, 1'b0);
            check("t4_overrun", 64'(overrun), 64'(k > BUF));
            check("t4_head_left", 64'(sample_left), 64'h1001);
        end
        check("t4_head_right", 64'(sample_right), 64'h2001);

        // Clear alone, then clear colliding with a drop
        overrun_clr = 1'b1;
        @(negedge por_clk);
        overrun_clr = 1'b0;
        check("t5_clr_alone", 64'(overrun), 64'd0);
        frame(32'h7777, 32'h8888, 16, 1'b1);
        check("t5_clr_vs_drop", 64'(overrun), 64'd1);
        check("t5_head_kept", 64'(sample_left), 64'h1001);

        sample_ready = 1'b1;
        repeat (10) @(negedge por_clk);
        check("t5_drain_count", 64'(got.size()), 64'(BUF));
        for (int i = 0; i < BUF; i++) begin
            check("t5_drain_pair", 64'(got[i]), 64'({16'(16'h1001 + i), 16'(16'h2001 + i)}));
        end
        check("t5_drained_valid", 64'(sample_valid), 64'd0);

        // Asynchronous reset while a pair is waiting
        sample_ready = 1'b0;
        frame(32'hCAFE, 32'hF00D, 16, 1'b0);
        check("t6_valid_before", 64'(sample_valid), 64'd1);
        check("t6_left_before", 64'(sample_left), 64'hCAFE);
        rst_n = 1'b0;
        #1;
        check("t6_rst_left", 64'(sample_left), 64'd0);
        check("t6_rst_right", 64'(sample_right), 64'd0);
        check("t6_rst_valid", 64'(sample_valid), 64'd0);
        check("t6_rst_overrun", 64'(overrun), 64'd0);
        @(negedge por_clk);
        rst_n = 1'b1;
        frame(32'h0101, 32'h0202, 16, 1'b0);
        check("t6_no_pair", 64'(sample_valid), 64'd0);
        frame(32'h0303, 32'h0404, 16, 1'b0);
        check("t6_valid_after", 64'(sample_valid), 64'd1);
        check("t6_pair_after", 64'({sample_left, sample_right}), 64'h0303_0404);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

I2S receiver (Philips format), the capture-side counterpart of the DAC I2S transmitter in AudVid. Accepts an externally clocked I2S stream (ADC/codec as bus master), oversamples BCLK/WS/DATA in the system clock domain, deserialises left and right words and presents each stereo pair on a valid/ready interface to the audio datapath. Sits between the board pins and AudVid's audio processing.

## Interface
Parameters:
- DATA_WIDTH, 16, bits kept per channel word (MSB-first); range 8..32
- FIFO_DEPTH, 4, stereo pairs buffered when I2S_RX_FIFO_EN is defined (power of two); ignored otherwise

Ports:
- CLK  in  1  system clock, 100 MHz
- Reset  in  1  asynchronous, active-low reset
- I2S_RX_CLK  in  1  serial bit clock from codec, asynchronous to CLK
- I2S_RX_WS  in  1  word select, 0 = left, 1 = right
- I2S_RX_DATA  in  1  serial data, MSB first
- SAMPLE_LEFT  out  DATA_WIDTH  left word of the head pair
- SAMPLE_RIGHT  out  DATA_WIDTH  right word of the head pair
- SAMPLE_VALID  out  1  head pair available
- SAMPLE_READY  in  1  consumer accepts head pair
- OVERRUN  out  1  sticky: a complete pair was dropped
- OVERRUN_CLR  in  1  synchronous clear of OVERRUN

## Operation
- All three pins pass through 2-FF synchronisers; a third register on BCLK gives rising-edge strobe `rise = s2 & ~s3`. Only `rise` cycles advance the receiver.
- On each `rise`: sample ws_now and bit. The bit belongs to channel ws_d (WS captured at previous `rise`) — the one-BCLK I2S delay.
- Shift: first DATA_WIDTH bits of a channel shift in MSB-first; later bits ignored (bit_cnt saturates at DATA_WIDTH). Words shorter than DATA_WIDTH are MSB-aligned, LSBs zero-filled.
- Word end: ws_now != ws_d on a `rise`; the bit captured on that edge is the last bit of channel ws_d and is included.
- States: SYNC (after reset; capture disabled) -> LEFT on the first `rise` where ws_now changes to 0; SYNC -> RIGHT is not allowed (a 0->1 change while in SYNC keeps SYNC). LEFT -> RIGHT at left word end (left word latched, have_left=1). RIGHT -> LEFT at right word end; if have_left, commit {left,right} as one pair, clear have_left.
- Commit handling: if buffer has room, or is full but SAMPLE_READY&&SAMPLE_VALID in the same cycle, pair is stored; otherwise pair dropped and OVERRUN set.
- OVERRUN: set wins over OVERRUN_CLR in the same cycle.
- Outputs SAMPLE_LEFT/RIGHT stable while SAMPLE_VALID=1 and SAMPLE_READY=0.

## Timing
- Reset values: SAMPLE_LEFT=0, SAMPLE_RIGHT=0, SAMPLE_VALID=0, OVERRUN=0; state SYNC, buffer empty, have_left=0, bit_cnt=0.
- Reset mid-frame: partial words discarded; receiver resynchronises at the next WS 1->0 change.
- BCLK high and low phases must each last >= 3 CLK cycles (BCLK <= ~16 MHz); no requirement beyond that.
- Latency: SAMPLE_VALID rises on the 3rd CLK edge after the pin-level BCLK rising edge carrying the right-word end (2 sync + 1 commit register), buffer previously empty.
- Handshake: transfer when SAMPLE_VALID && SAMPLE_READY at a CLK edge; next pair (if any) visible the following cycle; no combinational READY->VALID path.

## Configuration
- I2S_RX_FIFO_EN defined: FIFO_DEPTH-entry pair FIFO between commit and output; overrun only when full with no pop that cycle.
- Not defined: single holding register (depth 1); SAMPLE_VALID clears on transfer; a commit while occupied and not read drops the new pair.

## Structure
- Package i2s_rx_pkg: state enum (SYNC, LEFT, RIGHT), channel constants CH_LEFT=0/CH_RIGHT=1, sync-stage count constant 2.
- Sub-module i2s_rx_fifo (registered-output, first-word-fall-through pair FIFO), instantiated only under I2S_RX_FIFO_EN.

## Test plan
- 32-bit slots, DATA_WIDTH=16, left=16'hA5C3, right=16'h1234, READY=1 -> one pair {A5C3,1234}, VALID for 1 cycle, OVERRUN=0.
- 12-bit slots, left=12'hFFF, right=12'h801 -> SAMPLE_LEFT=16'hFFF0, SAMPLE_RIGHT=16'h8010.
- Release reset mid right word, then 3 full frames -> exactly 3 pairs, first partial frame not emitted.
- READY=0 for 6 frames, depth 1 -> first pair held unchanged, OVERRUN=1 after 2nd frame; with I2S_RX_FIFO_EN, FIFO_DEPTH=4 -> OVERRUN=1 after 5th frame, first 4 pairs read back in order.
- OVERRUN_CLR asserted in same cycle as a drop -> OVERRUN stays 1; asserted alone -> 0 next cycle.
- Reset asserted while VALID=1 -> all outputs 0 immediately (asynchronous), no pair after release until a full frame.
